// File: rtl/clock_switch_sequencer_if.sv
// Request/acknowledge handshake from the housekeeping registers, plus the
// clock-mux and divider selects that go to the clocking block.
interface clock_switch_sequencer_if;
  logic       cfg_req;
  logic       cfg_ext_sel;
  logic [2:0] cfg_sel;
  logic [2:0] cfg_sel2;
  logic       pll_ena;
  logic       cfg_ack;
  logic       cfg_err;
  logic       busy;
  logic       ext_clk_sel;
  logic [2:0] sel;
  logic [2:0] sel2;

  modport master (
    output cfg_req, cfg_ext_sel, cfg_sel, cfg_sel2, pll_ena,
    input  cfg_ack, cfg_err, busy, ext_clk_sel, sel, sel2
  );

  modport slave (
    input  cfg_req, cfg_ext_sel, cfg_sel, cfg_sel2, pll_ena,
    output cfg_ack, cfg_err, busy, ext_clk_sel, sel, sel2
  );
endinterface

// File: rtl/clock_switch_sequencer.sv
// Glitch-safe clock reconfiguration sequencer.
// Parks the core clock on the external source, changes the PLL dividers,
// waits for them to settle, then applies the requested source.
//
// state  | meaning
// IDLE   | waiting for cfg_req; targets latched on acceptance
// PARK   | ext_clk_sel forced to 1, waiting SWITCH_CYCLES before divider change
// SETTLE | dividers updated, waiting SETTLE_CYCLES before applying source
// ACK    | cfg_ack held high until cfg_req returns low
module clock_switch_sequencer #(
  parameter int SWITCH_CYCLES = 4,
  parameter int SETTLE_CYCLES = 16
) (
  input logic                        pll_clk,
  input logic                        resetb_async,
  clock_switch_sequencer_if.slave    bus
);

  localparam int MAX_CYC = (SWITCH_CYCLES > SETTLE_CYCLES) ? SWITCH_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] SWITCH_LOAD = CNT_W'(SWITCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, PARK, SETTLE, ACK} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             t_ext_q, t_ext_d;
  logic [2:0]       t_sel_q, t_sel_d;
  logic [2:0]       t_sel2_q, t_sel2_d;
  logic             ext_q, ext_d;
  logic [2:0]       sel_q, sel_d;
  logic [2:0]       sel2_q, sel2_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic             busy_q, busy_d;

  // State, counter, latched targets and all registered outputs.
  always_ff @(posedge pll_clk or negedge resetb_async) begin
    if (!resetb_async) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      t_ext_q  <= 1'b1;
      t_sel_q  <= '0;
      t_sel2_q <= '0;
      ext_q    <= 1'b1;
      sel_q    <= '0;
      sel2_q   <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      t_ext_q  <= t_ext_d;
      t_sel_q  <= t_sel_d;
      t_sel2_q <= t_sel2_d;
      ext_q    <= ext_d;
      sel_q    <= sel_d;
      sel2_q   <= sel2_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state and next-output decode; sel/sel2 only move on PARK exit,
  // which is what keeps the divided clock off the core during a change.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    t_ext_d  = t_ext_q;
    t_sel_d  = t_sel_q;
    t_sel2_d = t_sel2_q;
    ext_d    = ext_q;
    sel_d    = sel_q;
    sel2_d   = sel2_q;
    ack_d    = ack_q;
    err_d    = err_q;
    busy_d   = busy_q;
    unique case (state_q)
      IDLE: begin
        if (bus.cfg_req) begin
          t_ext_d  = bus.cfg_ext_sel;
          t_sel_d  = bus.cfg_sel;
          t_sel2_d = bus.cfg_sel2;
          err_d    = 1'b0;
          if (!bus.cfg_ext_sel && !bus.pll_ena) begin
            err_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = ACK;
          end else if (bus.cfg_sel == sel_q && bus.cfg_sel2 == sel2_q) begin
            ext_d   = bus.cfg_ext_sel;
            ack_d   = 1'b1;
            state_d = ACK;
          end else begin
            ext_d   = 1'b1;
            busy_d  = 1'b1;
            cnt_d   = SWITCH_LOAD;
            state_d = PARK;
          end
        end
      end
      PARK: begin
        if (cnt_q == '0) begin
          sel_d   = t_sel_q;
          sel2_d  = t_sel2_q;
          cnt_d   = SETTLE_LOAD;
          state_d = SETTLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          busy_d  = 1'b0;
          ack_d   = 1'b1;
          state_d = ACK;
          // PLL dropped out mid-sequence: stay parked and flag the request.
          if (!t_ext_q && !bus.pll_ena) begin
            ext_d = 1'b1;
            err_d = 1'b1;
          end else begin
            ext_d = t_ext_q;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ACK: begin
        if (!bus.cfg_req) begin
          ack_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.cfg_ack     = ack_q;
  assign bus.cfg_err     = err_q;
  assign bus.busy        = busy_q;
  assign bus.ext_clk_sel = ext_q;
  assign bus.sel         = sel_q;
  assign bus.sel2        = sel2_q;

endmodule
